// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: ALU op encodings, instruction
// field positions and FSM state encodings.
package alu_issue_pkg;

    localparam int XLEN         = 32;
    localparam int RIDX_W       = 4;
    localparam int OP_W         = 4;
    localparam int IMM_W        = 16;
    localparam int INST_IMM_BIT = 31;
    localparam int INST_OP_LSB  = 24;
    localparam int INST_RD_LSB  = 20;
    localparam int INST_RA_LSB  = 16;
    localparam int INST_RB_LSB  = 12;

    typedef enum logic [OP_W-1:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_AND  = 4'd2,
        ALU_OP_OR   = 4'd3,
        ALU_OP_XOR  = 4'd4,
        ALU_OP_LSL  = 4'd5,
        ALU_OP_LSR  = 4'd6,
        ALU_OP_ASR  = 4'd7,
        ALU_OP_MVB  = 4'd8,
        ALU_OP_MVT  = 4'd9,
        ALU_OP_SEQ  = 4'd10,
        ALU_OP_SLT  = 4'd11,
        ALU_OP_SLTE = 4'd12
    } alu_op_e;

    typedef enum logic [1:0] {
        ISSUE_IDLE = 2'd0,
        ISSUE_EXEC = 2'd1,
        ISSUE_WB   = 2'd2
    } issue_state_e;

    // Encodings 13..15 are undefined and must raise illegal instead of writing back.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        logic legal;
        case (op)
            ALU_OP_ADD, ALU_OP_SUB, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR,
            ALU_OP_LSL, ALU_OP_LSR, ALU_OP_ASR, ALU_OP_MVB, ALU_OP_MVT,
            ALU_OP_SEQ, ALU_OP_SLT, ALU_OP_SLTE: legal = 1'b1;
            default:                             legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_issue_regfile.sv
// 16x32 register file: two operand read ports, one debug read port and one
// synchronous write port; r0 always reads as zero.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int              NREGS     = 16,
    parameter logic [XLEN-1:0] RESET_VAL = 32'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i,
    input  logic [RIDX_W-1:0] ra_addr_i,
    output logic [XLEN-1:0]   ra_data_o,
    input  logic [RIDX_W-1:0] rb_addr_i,
    output logic [XLEN-1:0]   rb_data_o,
    input  logic [RIDX_W-1:0] dbg_addr_i,
    output logic [XLEN-1:0]   dbg_data_o
);

    logic [XLEN-1:0] mem_q [NREGS];

    // Storage update: reset reloads every entry, writes aimed at r0 are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= RESET_VAL;
            end
        end else if (we_i && (waddr_i != 4'd0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign ra_data_o  = (ra_addr_i  == 4'd0) ? {XLEN{1'b0}} : mem_q[ra_addr_i];
    assign rb_data_o  = (rb_addr_i  == 4'd0) ? {XLEN{1'b0}} : mem_q[rb_addr_i];
    assign dbg_data_o = (dbg_addr_i == 4'd0) ? {XLEN{1'b0}} : mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_issue.sv
// Serialized issue stage: accepts one register-format instruction, feeds the
// external ALU from registered operands and writes the result back.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int              NREGS     = 16,
    parameter logic [XLEN-1:0] RESET_VAL = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] inst,
    output logic        inst_ready,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_res,
    output logic        wb_valid,
    output logic [3:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [3:0]  dbg_reg,
    output logic [31:0] dbg_data
);

    issue_state_e      state_q,    state_d;
    logic [OP_W-1:0]   alu_op_q,   alu_op_d;
    logic [XLEN-1:0]   alu_a_q,    alu_a_d;
    logic [XLEN-1:0]   alu_b_q,    alu_b_d;
    logic [RIDX_W-1:0] rd_q,       rd_d;
    logic [RIDX_W-1:0] wb_reg_q,   wb_reg_d;
    logic [XLEN-1:0]   wb_data_q,  wb_data_d;
    logic              wb_valid_q, wb_valid_d;
    logic              illegal_q,  illegal_d;

    logic              accept_s;
    logic              inst_imm_s;
    logic [OP_W-1:0]   inst_op_s;
    logic [RIDX_W-1:0] inst_rd_s;
    logic [RIDX_W-1:0] inst_ra_s;
    logic [RIDX_W-1:0] inst_rb_s;
    logic [XLEN-1:0]   imm_ext_s;
    logic [XLEN-1:0]   ra_data_s;
    logic [XLEN-1:0]   rb_data_s;
    logic              unused_inst_bits_s;

    assign inst_imm_s         = inst[INST_IMM_BIT];
    assign inst_op_s          = inst[INST_OP_LSB +: OP_W];
    assign inst_rd_s          = inst[INST_RD_LSB +: RIDX_W];
    assign inst_ra_s          = inst[INST_RA_LSB +: RIDX_W];
    assign inst_rb_s          = inst[INST_RB_LSB +: RIDX_W];
    assign imm_ext_s          = {{(XLEN-IMM_W){1'b0}}, inst[IMM_W-1:0]};
    assign unused_inst_bits_s = ^inst[30:28];

    // Ready drops combinationally with rst so a handshake during reset is never taken.
    assign inst_ready = (state_q == ISSUE_IDLE) & ~rst;
    assign accept_s   = inst_valid & inst_ready;

    // Operands are read at accept time, while the instruction word is still on the bus.
    alu_issue_regfile #(
        .NREGS     (NREGS),
        .RESET_VAL (RESET_VAL)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wb_valid_q),
        .waddr_i    (wb_reg_q),
        .wdata_i    (wb_data_q),
        .ra_addr_i  (inst_ra_s),
        .ra_data_o  (ra_data_s),
        .rb_addr_i  (inst_rb_s),
        .rb_data_o  (rb_data_s),
        .dbg_addr_i (dbg_reg),
        .dbg_data_o (dbg_data)
    );

    // Next-state logic of the IDLE -> EXEC -> WB sequence
    always_comb begin
        state_d = state_q;
        case (state_q)
            ISSUE_IDLE: begin
                if (accept_s) begin
                    state_d = ISSUE_EXEC;
                end else begin
                    state_d = ISSUE_IDLE;
                end
            end
            ISSUE_EXEC: begin
                if (op_is_legal(alu_op_q)) begin
                    state_d = ISSUE_WB;
                end else begin
                    state_d = ISSUE_IDLE;
                end
            end
            ISSUE_WB: state_d = ISSUE_IDLE;
            default:  state_d = ISSUE_IDLE;
        endcase
    end

    // Datapath next values: operand capture on accept, result or illegal flag out of EXEC
    always_comb begin
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        rd_d       = rd_q;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        wb_valid_d = 1'b0;
        illegal_d  = 1'b0;
        if (accept_s) begin
            alu_op_d = inst_op_s;
            alu_a_d  = ra_data_s;
            alu_b_d  = inst_imm_s ? imm_ext_s : rb_data_s;
            rd_d     = inst_rd_s;
        end else begin
            rd_d     = rd_q;
        end
        if (state_q == ISSUE_EXEC) begin
            if (op_is_legal(alu_op_q)) begin
                wb_valid_d = 1'b1;
                wb_reg_d   = rd_q;
                wb_data_d  = alu_res;
            end else begin
                illegal_d  = 1'b1;
            end
        end else begin
            wb_valid_d = 1'b0;
        end
    end

    // State and datapath registers; rst overrides any transfer in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ISSUE_IDLE;
            alu_op_q   <= 4'd0;
            alu_a_q    <= 32'd0;
            alu_b_q    <= 32'd0;
            rd_q       <= 4'd0;
            wb_reg_q   <= 4'd0;
            wb_data_q  <= 32'd0;
            wb_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            rd_q       <= rd_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_valid_q <= wb_valid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign wb_valid = wb_valid_q;
    assign wb_reg   = wb_reg_q;
    assign wb_data  = wb_data_q;
    assign illegal  = illegal_q;

endmodule
